// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT_ACK,
    HALTED
  } state_e;

  // Encoded in ascending priority so kinds can be compared directly.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP,
    RD_EXC
  } redirect_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: exception > jump > branch > pending redirect > pc+4.
// Misaligned jump/branch targets are turned into exceptions here.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic [31:0] pc_i,
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  redirect_e   pend_kind_i,
  input  logic [31:0] pend_target_i,
  output redirect_e   new_kind_o,
  output logic [31:0] new_target_o,
  output logic        misalign_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] next_pc_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (an unassigned path in always_comb infers a latch).
    new_kind_o   = RD_NONE;
    new_target_o = '0;
    misalign_o   = 1'b0;
    fault_addr_o = '0;

    if (exc_i) begin
      new_kind_o   = RD_EXC;
      new_target_o = EXC_VECTOR;
    end else if (jump_i) begin
      if (is_misaligned(jump_target_i)) begin
        new_kind_o   = RD_EXC;
        new_target_o = EXC_VECTOR;
        misalign_o   = 1'b1;
        fault_addr_o = jump_target_i;
      end else begin
        new_kind_o   = RD_JUMP;
        new_target_o = jump_target_i;
      end
    end else if (branch_taken_i) begin
      if (is_misaligned(branch_target_i)) begin
        new_kind_o   = RD_EXC;
        new_target_o = EXC_VECTOR;
        misalign_o   = 1'b1;
        fault_addr_o = branch_target_i;
      end else begin
        new_kind_o   = RD_BRANCH;
        new_target_o = branch_target_i;
      end
    end

    if (new_kind_o != RD_NONE) begin
      next_pc_o = new_target_o;
    end else if (pend_kind_i != RD_NONE) begin
      next_pc_o = pend_target_i;
    end else begin
      next_pc_o = pc_i + INSTR_BYTES;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer with imem req/ack handshake.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        exc_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic [31:0] epc_o,
  output logic        misalign_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        pc_valid_q, pc_valid_d;
  logic [31:0] epc_q, epc_d;
  logic        misalign_q, misalign_d;
  redirect_e   pend_kind_q, pend_kind_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        halt_pend_q, halt_pend_d;

  redirect_e   new_kind;
  logic [31:0] new_target;
  logic        new_misalign;
  logic [31:0] fault_addr;
  logic [31:0] next_pc;
  logic        redirect_new;
  logic        squash;

  pc_next_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_mux (
    .pc_i           (pc_q),
    .exc_i          (exc_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .pend_kind_i    (pend_kind_q),
    .pend_target_i  (pend_target_q),
    .new_kind_o     (new_kind),
    .new_target_o   (new_target),
    .misalign_o     (new_misalign),
    .fault_addr_o   (fault_addr),
    .next_pc_o      (next_pc)
  );

  assign redirect_new = (new_kind != RD_NONE);

  // pc only moves on completion or redirect, so it is also the outstanding fetch address.
  assign imem_addr_o = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    pc_valid_d    = 1'b0;
    epc_d         = epc_q;
    misalign_d    = 1'b0;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    halt_pend_d   = halt_pend_q;
    imem_req_o    = 1'b0;
    squash        = 1'b0;

    unique case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        if (redirect_new) begin
          pc_d = next_pc;
        end else if (!stall_i && !halt_i) begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            pc_out_d   = pc_q;
            pc_valid_d = 1'b1;
            pc_d       = next_pc;
          end else begin
            state_d = WAIT_ACK;
          end
        end
        if (halt_i) state_d = HALTED;
      end

      WAIT_ACK: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          squash = redirect_new || (pend_kind_q != RD_NONE);
          if (!squash) begin
            pc_out_d   = pc_q;
            pc_valid_d = 1'b1;
          end
          pc_d          = next_pc;
          pend_kind_d   = RD_NONE;
          pend_target_d = '0;
          halt_pend_d   = 1'b0;
          state_d       = (halt_pend_q || halt_i) ? HALTED : FETCH;
        end else begin
          // Ties keep the older redirect.
          if (new_kind > pend_kind_q) begin
            pend_kind_d   = new_kind;
            pend_target_d = new_target;
          end
          if (halt_i) halt_pend_d = 1'b1;
        end
      end

      HALTED: if (resume_i) state_d = FETCH;

      default: state_d = BOOT;
    endcase

    if ((state_q == FETCH || state_q == WAIT_ACK) && new_kind == RD_EXC) begin
      epc_d      = new_misalign ? fault_addr : pc_q;
      misalign_d = new_misalign;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, pc_valid_d};
    stall_cnt_d = stall_cnt_q +
                  {31'd0, (state_q == FETCH && stall_i) || state_q == WAIT_ACK};
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_out_q      <= '0;
      pc_valid_q    <= 1'b0;
      epc_q         <= '0;
      misalign_q    <= 1'b0;
      pend_kind_q   <= RD_NONE;
      pend_target_q <= '0;
      halt_pend_q   <= 1'b0;
`ifdef PC_SEQ_PERF_EN
      fetch_cnt_q   <= '0;
      stall_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      pc_valid_q    <= pc_valid_d;
      epc_q         <= epc_d;
      misalign_q    <= misalign_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
      halt_pend_q   <= halt_pend_d;
`ifdef PC_SEQ_PERF_EN
      fetch_cnt_q   <= fetch_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
`endif
    end
  end

  assign pc_o       = pc_out_q;
  assign pc_valid_o = pc_valid_q;
  assign epc_o      = epc_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch streaming, delayed ack, squash,
// misalignment, stall, exception+halt, PC wrap and reset during a fetch.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        exc_i;
  logic        halt_i;
  logic        resume_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [31:0] epc_o;
  logic        misalign_o;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  logic ack_tied;
  logic ack_man;
  int   checks;
  int   failures;

  assign imem_ack_i = ack_tied ? imem_req_o : ack_man;

  pc_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .exc_i          (exc_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .epc_o          (epc_o),
    .misalign_o     (misalign_o)
`ifdef PC_SEQ_PERF_EN
    ,
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = '0;
    jump_i = 1'b0;
    jump_target_i = '0;
    exc_i = 1'b0;
    halt_i = 1'b0;
    resume_i = 1'b0;
    ack_tied = 1'b0;
    ack_man = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(pc_valid_o), 32'd0);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);

    // Ack tied to req: streaming fetch 0,4,8,C
    ack_tied = 1'b1;
    cyc(); #1;
    check("s1_req", 32'(imem_req_o), 32'd1);
    check("s1_addr0", imem_addr_o, 32'h0);
    check("s1_valid_early", 32'(pc_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("s1_valid", 32'(pc_valid_o), 32'd1);
      check("s1_pc_o", pc_o, 32'(i * 4));
      check("s1_addr", imem_addr_o, 32'((i + 1) * 4));
    end

    // Ack delayed 3 cycles on address 0x4
    do_reset();
    ack_tied = 1'b1;
    cyc();
    cyc();
    ack_tied = 1'b0;
    ack_man = 1'b0;
    #1;
    check("s2_valid0", 32'(pc_valid_o), 32'd1);
    check("s2_pc_o0", pc_o, 32'h0);
    check("s2_addr_a1", imem_addr_o, 32'h4);
    for (int i = 1; i < 4; i++) begin
      cyc();
      if (i == 3) ack_man = 1'b1;
      #1;
      check("s2_addr_hold", imem_addr_o, 32'h4);
      check("s2_req_hold", 32'(imem_req_o), 32'd1);
      check("s2_no_valid", 32'(pc_valid_o), 32'd0);
    end
    cyc();
    ack_man = 1'b0;
    #1;
    check("s2_valid4", 32'(pc_valid_o), 32'd1);
    check("s2_pc_o4", pc_o, 32'h4);
    check("s2_addr8", imem_addr_o, 32'h8);

    // Jump during WAIT_ACK on 0x8 squashes that fetch
    cyc(); #1;
    check("s2_single_pulse", 32'(pc_valid_o), 32'd0);
    jump_i = 1'b1;
    jump_target_i = 32'h100;
    cyc();
    jump_i = 1'b0;
    #1;
    check("s3_addr_hold", imem_addr_o, 32'h8);
    ack_man = 1'b1;
    cyc();
    ack_man = 1'b0;
    #1;
    check("s3_squash", 32'(pc_valid_o), 32'd0);
    check("s3_addr_target", imem_addr_o, 32'h100);
    check("s3_req", 32'(imem_req_o), 32'd1);
    ack_tied = 1'b1;
    cyc(); #1;
    check("s3_valid100", 32'(pc_valid_o), 32'd1);
    check("s3_pc_o100", pc_o, 32'h100);

    // Misaligned branch target 0x102
    branch_taken_i = 1'b1;
    branch_target_i = 32'h102;
    #1;
    check("s4_no_req", 32'(imem_req_o), 32'd0);
    cyc();
    branch_taken_i = 1'b0;
    #1;
    check("s4_misalign", 32'(misalign_o), 32'd1);
    check("s4_epc", epc_o, 32'h102);
    check("s4_addr_exc", imem_addr_o, 32'h80);
    cyc(); #1;
    check("s4_misalign_pulse", 32'(misalign_o), 32'd0);
    check("s4_pc_o80", pc_o, 32'h80);

    // Stall for 5 cycles at pc 0x20
    jump_i = 1'b1;
    jump_target_i = 32'h20;
    cyc();
    jump_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stall_i = 1'b1;
      #1;
      check("s5_stall_req", 32'(imem_req_o), 32'd0);
      check("s5_stall_addr", imem_addr_o, 32'h20);
      cyc();
    end
    stall_i = 1'b0;
    #1;
    check("s5_release_req", 32'(imem_req_o), 32'd1);
    check("s5_release_addr", imem_addr_o, 32'h20);
    cyc(); #1;
    check("s5_pc_o20", pc_o, 32'h20);

    // Exception and halt together at pc 0x24
    exc_i = 1'b1;
    halt_i = 1'b1;
    #1;
    check("s6_exc_no_req", 32'(imem_req_o), 32'd0);
    cyc();
    exc_i = 1'b0;
    halt_i = 1'b0;
    #1;
    check("s6_epc", epc_o, 32'h24);
    check("s6_halted_req", 32'(imem_req_o), 32'd0);
    check("s6_pc_exc", imem_addr_o, 32'h80);
    cyc(); #1;
    check("s6_still_halted", 32'(imem_req_o), 32'd0);
    resume_i = 1'b1;
    cyc();
    resume_i = 1'b0;
    #1;
    check("s6_resume_req", 32'(imem_req_o), 32'd1);
    check("s6_resume_addr", imem_addr_o, 32'h80);

    // PC wrap from 0xFFFF_FFFC
    cyc();
    jump_i = 1'b1;
    jump_target_i = 32'hFFFF_FFFC;
    cyc();
    jump_i = 1'b0;
    #1;
    check("s7_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    cyc(); #1;
    check("s7_pc_o_top", pc_o, 32'hFFFF_FFFC);
    check("s7_wrap_addr", imem_addr_o, 32'h0);

    // Reset mid-WAIT_ACK, then a stale ack
    ack_tied = 1'b0;
    ack_man = 1'b0;
    cyc(); #1;
    check("s8_wait_req", 32'(imem_req_o), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ack_man = 1'b1;
    #1;
    check("s8_rst_req", 32'(imem_req_o), 32'd0);
    check("s8_rst_pc_o", pc_o, 32'h0);
    check("s8_rst_epc", epc_o, 32'h0);
    cyc();
    ack_man = 1'b0;
    #1;
    check("s8_stale_valid", 32'(pc_valid_o), 32'd0);
    check("s8_req", 32'(imem_req_o), 32'd1);
    check("s8_addr_rv", imem_addr_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
